execute_stage: RTL and testbench

- Y86-64 execute stage. Sits directly downstream of the register-array read (decode) stage and consumes its valA/valB.
- Computes valE with the ALU, evaluates the branch/cmov condition, and owns the condition-code register (ZF/SF/OF).
- Presents a registered result to the memory stage over a valid/ready handshake, with a one-entry output register.

---
 rtl/execute_stage_if.sv | 40 ++++
 rtl/execute_stage.sv | 170 +++++++++++++++++
 tb/tb_execute_stage.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Decode -> execute -> memory pipeline bus for the Y86-64 execute stage.
// slave is the execute stage; master is whatever drives decode and consumes results.
interface execute_stage_if #(parameter int W = 64);
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [2:0]   in_stat;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [W-1:0] in_valA;
  logic [W-1:0] in_valB;
  logic [W-1:0] in_valC;
  logic [3:0]   in_dstE;
  logic [3:0]   in_dstM;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_stat;
  logic [3:0]   out_icode;
  logic         out_cnd;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic [3:0]   out_dstE;
  logic [3:0]   out_dstM;
  logic [2:0]   cc_out;
  logic         halted;

  modport slave (
    input  in_valid, flush, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, out_ready,
    output in_ready, out_valid, out_stat, out_icode, out_cnd, out_valE, out_valA,
           out_dstE, out_dstM, cc_out, halted
  );

  modport master (
    output in_valid, flush, in_stat, in_icode, in_ifun, in_valA, in_valB, in_valC,
           in_dstE, in_dstM, out_ready,
    input  in_ready, out_valid, out_stat, out_icode, out_cnd, out_valE, out_valA,
           out_dstE, out_dstM, cc_out, halted
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition, one-entry output register.
// Define EXEC_MUL_EN to make OPq ifun 5 a signed multiply; otherwise it is an illegal function.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);
  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [3:0] I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4, I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8, I_RET = 4'h9;
  localparam logic [3:0] I_PUSH = 4'hA, I_POP = 4'hB;
  localparam logic [2:0] S_AOK = 3'd1, S_INS = 3'd4;
  localparam logic [W-1:0] MINUS8 = {{(W-4){1'b1}}, 4'h8};
  localparam logic [W-1:0] PLUS8  = {{(W-4){1'b0}}, 4'h8};

  // cc is {ZF,SF,OF}; illegal functions never reach here as taken.
  function automatic logic condTrue(input logic [3:0] fn, input logic [2:0] cc);
    logic lt;
    lt = cc[1] ^ cc[0];
    case (fn)
      4'h0:    condTrue = 1'b1;
      4'h1:    condTrue = lt | cc[2];
      4'h2:    condTrue = lt;
      4'h3:    condTrue = cc[2];
      4'h4:    condTrue = ~cc[2];
      4'h5:    condTrue = ~lt;
      4'h6:    condTrue = ~lt & ~cc[2];
      default: condTrue = 1'b0;
    endcase
  endfunction

  state_t       stateR, stateNext_s;
  logic         outValid_r, outCnd_r;
  logic [2:0]   outStat_r, cc_r;
  logic [3:0]   outIcode_r, outDstE_r, outDstM_r;
  logic [W-1:0] outValE_r, outValA_r;
  logic [W-1:0] aluA_s, aluB_s, valE_s;
  logic         of_s, opLegal_s, condLegal_s, isCond_s, cnd_s, illegal_s;
  logic         inReady_s, accept_s, ccWrite_s;
  logic [2:0]   stat_s;
  logic [3:0]   dstE_s;
`ifdef EXEC_MUL_EN
  logic [2*W-1:0] prod_s;
`endif

  assign inReady_s = (stateR == RUN) && (!outValid_r || bus.out_ready);
  assign accept_s  = bus.in_valid && inReady_s && !bus.flush;

  // ALU operand selection by instruction class
  always_comb begin
    aluA_s = '0;
    aluB_s = '0;
    case (bus.in_icode)
      I_RRMOV:          aluA_s = bus.in_valA;
      I_IRMOV:          aluA_s = bus.in_valC;
      I_RMMOV, I_MRMOV: begin aluA_s = bus.in_valC; aluB_s = bus.in_valB; end
      I_OPQ:            begin aluA_s = bus.in_valA; aluB_s = bus.in_valB; end
      I_CALL, I_PUSH:   begin aluA_s = MINUS8;      aluB_s = bus.in_valB; end
      I_RET, I_POP:     begin aluA_s = PLUS8;       aluB_s = bus.in_valB; end
      default:          begin aluA_s = '0;          aluB_s = '0;          end
    endcase
  end

  // ALU result and overflow; non-OPq instructions always add
  always_comb begin
    valE_s    = aluB_s + aluA_s;
    of_s      = 1'b0;
    opLegal_s = 1'b1;
`ifdef EXEC_MUL_EN
    prod_s    = '0;
`endif
    case ((bus.in_icode == I_OPQ) ? bus.in_ifun : 4'h0)
      4'h0: of_s = (aluA_s[W-1] == aluB_s[W-1]) && (valE_s[W-1] != aluA_s[W-1]);
      4'h1: begin
        valE_s = aluB_s - aluA_s;
        of_s   = (aluB_s[W-1] != aluA_s[W-1]) && (valE_s[W-1] != aluB_s[W-1]);
      end
      4'h2: valE_s = aluB_s & aluA_s;
      4'h3: valE_s = aluB_s ^ aluA_s;
`ifdef EXEC_MUL_EN
      4'h5: begin
        prod_s = $signed({{W{aluB_s[W-1]}}, aluB_s}) * $signed({{W{aluA_s[W-1]}}, aluA_s});
        valE_s = prod_s[W-1:0];
        of_s   = !((&prod_s[2*W-1:W-1]) || !(|prod_s[2*W-1:W-1]));
      end
`endif
      default: begin
        valE_s    = '0;
        opLegal_s = 1'b0;
      end
    endcase
  end

  // Condition, status and destination for the presented instruction
  always_comb begin
    isCond_s    = (bus.in_icode == I_RRMOV) || (bus.in_icode == I_JXX);
    condLegal_s = (bus.in_ifun <= 4'h6);
    cnd_s       = isCond_s && condLegal_s && condTrue(bus.in_ifun, cc_r);
    illegal_s   = (bus.in_icode > I_POP) || ((bus.in_icode == I_OPQ) && !opLegal_s)
                  || (isCond_s && !condLegal_s);
    stat_s      = illegal_s ? S_INS : bus.in_stat;
    dstE_s      = ((bus.in_icode == I_RRMOV) && !cnd_s) ? RNONE : bus.in_dstE;
    ccWrite_s   = accept_s && (bus.in_icode == I_OPQ) && (bus.in_stat == S_AOK) && opLegal_s;
  end

  // Run/halt next state: any accepted non-AOK instruction halts until reset
  always_comb begin
    stateNext_s = stateR;
    case (stateR)
      RUN:     stateNext_s = (accept_s && (stat_s != S_AOK)) ? HALTED : RUN;
      HALTED:  stateNext_s = HALTED;
      default: stateNext_s = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) stateR <= RUN;
    else     stateR <= stateNext_s;
  end

  // Condition-code register
  always_ff @(posedge clk) begin
    if (rst)            cc_r <= 3'b100;
    else if (ccWrite_s) cc_r <= {(valE_s == '0), valE_s[W-1], of_s};
  end

  // Output register; flush wins over a simultaneous accept
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_r <= 1'b0;
      outStat_r  <= S_AOK;
      outIcode_r <= 4'h1;
      outCnd_r   <= 1'b0;
      outValE_r  <= '0;
      outValA_r  <= '0;
      outDstE_r  <= RNONE;
      outDstM_r  <= RNONE;
    end else if (bus.flush) begin
      outValid_r <= 1'b0;
    end else if (accept_s) begin
      outValid_r <= 1'b1;
      outStat_r  <= stat_s;
      outIcode_r <= bus.in_icode;
      outCnd_r   <= cnd_s;
      outValE_r  <= valE_s;
      outValA_r  <= bus.in_valA;
      outDstE_r  <= dstE_s;
      outDstM_r  <= bus.in_dstM;
    end else if (bus.out_ready) begin
      outValid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = inReady_s;
  assign bus.out_valid = outValid_r;
  assign bus.out_stat  = outStat_r;
  assign bus.out_icode = outIcode_r;
  assign bus.out_cnd   = outCnd_r;
  assign bus.out_valE  = outValE_r;
  assign bus.out_valA  = outValA_r;
  assign bus.out_dstE  = outDstE_r;
  assign bus.out_dstM  = outDstM_r;
  assign bus.cc_out    = cc_r;
  assign bus.halted    = (stateR == HALTED);
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus a randomized
// back-to-back stream checked against an arithmetic reference model.
module tb_execute_stage;
  localparam int W = 64;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         errors = 0;
  int         checks = 0;
  logic [2:0] mcc = 3'b100;

  always #5 clk = ~clk;

  execute_stage_if #(.W(W)) bus ();
  execute_stage #(.W(W), .RNONE(4'hF)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic condTrue(input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Expected {stat,icode,cnd,valE,valA,dstE,dstM} and the CC after this instruction.
  function automatic logic [143:0] refModel(input logic [3:0] ic, input logic [3:0] fn,
      input logic [2:0] st, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
      input logic [3:0] de, input logic [3:0] dm, input logic [2:0] ccIn, output logic [2:0] ccNew);
    logic [63:0] e;
    logic        cnd, ok, of;
    logic [64:0] wide;
    logic signed [127:0] p;
    e = 64'd0; cnd = 1'b0; ok = 1'b1; of = 1'b0; ccNew = ccIn;
    case (ic)
      4'h0, 4'h1: e = 64'd0;
      4'h2: begin e = a; ok = (fn <= 4'd6); cnd = ok && condTrue(fn, ccIn); end
      4'h3: e = c;
      4'h4, 4'h5: e = b + c;
      4'h6: begin
        case (fn)
          4'd0: begin wide = {b[63], b} + {a[63], a}; e = wide[63:0]; of = wide[64] != wide[63]; end
          4'd1: begin wide = {b[63], b} - {a[63], a}; e = wide[63:0]; of = wide[64] != wide[63]; end
          4'd2: e = b & a;
          4'd3: e = b ^ a;
`ifdef EXEC_MUL_EN
          4'd5: begin p = $signed(b) * $signed(a); e = p[63:0]; of = (p != {{64{p[63]}}, p[63:0]}); end
`endif
          default: ok = 1'b0;
        endcase
        if (ok && st == 3'd1) ccNew = {(e == 64'd0), e[63], of};
      end
      4'h7: begin ok = (fn <= 4'd6); cnd = ok && condTrue(fn, ccIn); end
      4'h8, 4'hA: e = b - 64'd8;
      4'h9, 4'hB: e = b + 64'd8;
      default: ok = 1'b0;
    endcase
    return {ok ? st : 3'd4, ic, cnd, e, a, (ic == 4'h2 && !cnd) ? 4'hF : de, dm};
  endfunction

  function automatic logic [143:0] dutVec();
    return {bus.out_stat, bus.out_icode, bus.out_cnd, bus.out_valE, bus.out_valA,
            bus.out_dstE, bus.out_dstM};
  endfunction

  function automatic logic [63:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic present(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] st,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
      input logic [3:0] de, input logic [3:0] dm);
    bus.in_valid = 1'b1; bus.in_icode = ic; bus.in_ifun = fn; bus.in_stat = st;
    bus.in_valA = a; bus.in_valB = b; bus.in_valC = c; bus.in_dstE = de; bus.in_dstM = dm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); bus.out_ready = 1'b1;
    tick();
    rst = 1'b0; mcc = 3'b100;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.cc_out !== 3'b100) begin errors++; $display("FAIL reset_cc: got %b want 100", bus.cc_out); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (dutVec() !== {3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF})
      begin errors++; $display("FAIL reset_outputs: got %h want %h", dutVec(), {3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF}); end
  endtask

  task automatic test_subq();
    logic [143:0] exp; logic [2:0] ncc;
    exp = refModel(4'h6, 4'h1, 3'd1, 64'd5, 64'd3, 64'd0, 4'h2, 4'hF, mcc, ncc);
    present(4'h6, 4'h1, 3'd1, 64'd5, 64'd3, 64'd0, 4'h2, 4'hF);
    tick(); idle();
    checks++; if (dutVec() !== exp) begin errors++; $display("FAIL subq_out: got %h want %h", dutVec(), exp); end
    checks++; if (bus.out_valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL subq_valE: got %h want fffffffffffffffe", bus.out_valE); end
    checks++; if (bus.cc_out !== 3'b010) begin errors++; $display("FAIL subq_cc: got %b want 010", bus.cc_out); end
    mcc = ncc;
  endtask

  task automatic test_add_overflow_cmov();
    logic [143:0] exp; logic [2:0] ncc;
    exp = refModel(4'h6, 4'h0, 3'd1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF, mcc, ncc);
    present(4'h6, 4'h0, 3'd1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h1, 4'hF);
    tick();
    checks++; if (bus.out_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL addov_valE: got %h want 8000000000000000", bus.out_valE); end
    checks++; if (bus.cc_out !== 3'b011) begin errors++; $display("FAIL addov_cc: got %b want 011", bus.cc_out); end
    mcc = ncc;
    exp = refModel(4'h2, 4'h2, 3'd1, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF, mcc, ncc);
    present(4'h2, 4'h2, 3'd1, 64'h55, 64'd0, 64'd0, 4'h3, 4'hF);
    tick(); idle();
    checks++; if (bus.out_cnd !== 1'b0) begin errors++; $display("FAIL cmovl_cnd: got %b want 0", bus.out_cnd); end
    checks++; if (bus.out_dstE !== 4'hF) begin errors++; $display("FAIL cmovl_dstE: got %h want f", bus.out_dstE); end
    checks++; if (dutVec() !== exp) begin errors++; $display("FAIL cmovl_out: got %h want %h", dutVec(), exp); end
    mcc = ncc;
  endtask

  task automatic test_pointer();
    present(4'hA, 4'h0, 3'd1, 64'd7, 64'h100, 64'd0, 4'h4, 4'hF);
    tick();
    checks++; if (bus.out_valE !== 64'hF8) begin errors++; $display("FAIL pushq_valE: got %h want f8", bus.out_valE); end
    checks++; if (bus.cc_out !== mcc) begin errors++; $display("FAIL pushq_cc: got %b want %b", bus.cc_out, mcc); end
    present(4'hB, 4'h0, 3'd1, 64'd7, 64'h100, 64'd0, 4'h4, 4'h3);
    tick(); idle();
    checks++; if (bus.out_valE !== 64'h108) begin errors++; $display("FAIL popq_valE: got %h want 108", bus.out_valE); end
    checks++; if (bus.cc_out !== mcc) begin errors++; $display("FAIL popq_cc: got %b want %b", bus.cc_out, mcc); end
  endtask

  task automatic test_backpressure();
    logic [143:0] exp1, exp2; logic [2:0] ncc;
    idle(); bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp1 = refModel(4'h3, 4'h0, 3'd1, 64'd9, 64'd0, 64'h1234, 4'h5, 4'hF, mcc, ncc);
    present(4'h3, 4'h0, 3'd1, 64'd9, 64'd0, 64'h1234, 4'h5, 4'hF);
    tick();
    exp2 = refModel(4'h6, 4'h2, 3'd1, 64'hF0F0, 64'hFF00, 64'd0, 4'h6, 4'hF, mcc, ncc);
    present(4'h6, 4'h2, 3'd1, 64'hF0F0, 64'hFF00, 64'd0, 4'h6, 4'hF);
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", k, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || dutVec() !== exp1)
        begin errors++; $display("FAIL bp_hold cycle %0d: got %b/%h want 1/%h", k, bus.out_valid, dutVec(), exp1); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
    tick(); idle();
    checks++; if (dutVec() !== exp2) begin errors++; $display("FAIL bp_second: got %h want %h", dutVec(), exp2); end
    checks++; if (bus.cc_out !== ncc) begin errors++; $display("FAIL bp_cc: got %b want %b", bus.cc_out, ncc); end
    mcc = ncc;
  endtask

  task automatic test_flush();
    logic [143:0] exp; logic [2:0] ncc;
    exp = refModel(4'h6, 4'h3, 3'd1, 64'hA5, 64'h5A, 64'd0, 4'h7, 4'hF, mcc, ncc);
    present(4'h6, 4'h3, 3'd1, 64'hA5, 64'h5A, 64'd0, 4'h7, 4'hF);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || dutVec() !== exp)
      begin errors++; $display("FAIL flush_pre: got %b/%h want 1/%h", bus.out_valid, dutVec(), exp); end
    mcc = ncc;
    present(4'h6, 4'h1, 3'd1, 64'd1, 64'd1, 64'd0, 4'h7, 4'hF);
    bus.flush = 1'b1;
    tick(); idle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.cc_out !== mcc) begin errors++; $display("FAIL flush_cc: got %b want %b", bus.cc_out, mcc); end
  endtask

  task automatic test_back_to_back();
    logic [143:0] exp; logic [2:0] ncc;
    logic [3:0] ic, fn, de, dm;
    logic [63:0] a, b, c;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 240; i++) begin
      case (i % 3)
        0: ic = 4'h6;
        1: ic = ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h7;
        default: ic = 4'($urandom_range(0, 11));
      endcase
      if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
      else fn = 4'h0;
      a = pickVal(); b = pickVal(); c = pickVal();
      de = 4'($urandom_range(0, 14)); dm = 4'($urandom_range(0, 15));
      exp = refModel(ic, fn, 3'd1, a, b, c, de, dm, mcc, ncc);
      present(ic, fn, 3'd1, a, b, c, de, dm);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready it %0d: got %b want 1", i, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || dutVec() !== exp)
        begin errors++; $display("FAIL b2b_out it %0d: got %b/%h want 1/%h", i, bus.out_valid, dutVec(), exp); end
      checks++; if (bus.cc_out !== ncc) begin errors++; $display("FAIL b2b_cc it %0d: got %b want %b", i, bus.cc_out, ncc); end
      mcc = ncc;
    end
    idle();
  endtask

  task automatic test_opq_ifun5();
    logic [143:0] exp; logic [2:0] ncc; logic expHalt;
`ifdef EXEC_MUL_EN
    expHalt = 1'b0;
`else
    expHalt = 1'b1;
`endif
    exp = refModel(4'h6, 4'h5, 3'd1, 64'h1_0000_0000, 64'h3_0000_0001, 64'd0, 4'h2, 4'hF, mcc, ncc);
    present(4'h6, 4'h5, 3'd1, 64'h1_0000_0000, 64'h3_0000_0001, 64'd0, 4'h2, 4'hF);
    tick(); idle();
    checks++; if (dutVec() !== exp) begin errors++; $display("FAIL ifun5_out: got %h want %h", dutVec(), exp); end
    checks++; if (bus.cc_out !== ncc) begin errors++; $display("FAIL ifun5_cc: got %b want %b", bus.cc_out, ncc); end
    checks++; if (bus.halted !== expHalt) begin errors++; $display("FAIL ifun5_halted: got %b want %b", bus.halted, expHalt); end
    rst = 1'b1;
    tick();
    rst = 1'b0; mcc = 3'b100;
  endtask

  task automatic test_illegal();
    present(4'hC, 4'h0, 3'd1, 64'd1, 64'd2, 64'd3, 4'h1, 4'h2);
    tick();
    checks++; if (bus.out_stat !== 3'd4) begin errors++; $display("FAIL illegal_stat: got %0d want 4", bus.out_stat); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL illegal_halted: got %b want 1", bus.halted); end
    present(4'h6, 4'h0, 3'd1, 64'd1, 64'd2, 64'd0, 4'h1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready cycle %0d: got %b want 0", k, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1)
        begin errors++; $display("FAIL halt_drain cycle %0d: got valid=%b halted=%b want 0/1", k, bus.out_valid, bus.halted); end
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.halted !== 1'b0 || bus.in_ready !== 1'b1)
      begin errors++; $display("FAIL halt_reset: got halted=%b ready=%b want 0/1", bus.halted, bus.in_ready); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.in_stat = 3'd1; bus.in_icode = 4'h1; bus.in_ifun = 4'h0;
    bus.in_valA = 64'd0; bus.in_valB = 64'd0; bus.in_valC = 64'd0;
    bus.in_dstE = 4'hF; bus.in_dstM = 4'hF;
    test_reset();
    test_subq();
    test_add_overflow_cmov();
    test_pointer();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_opq_ifun5();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
